// File: rtl/mul16_seq_pkg.sv
// Shared definitions for the sequential 16x16 shift-and-add multiplier.
// Holds the 2-bit FSM encoding, the iteration count and the fixed ALU
// control word used for every arithmetic step.
package mul16_seq_pkg;

    localparam int WIDTH      = 16;
    localparam int ITERATIONS = 16;
    localparam int CNT_W      = 4;

    // Counter value in the last DBL step, before the increment.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DBL  = 2'b10,
        DONE = 2'b11
    } state_t;

    // ALU control bits, MSB first: {zx, nx, zy, ny, f, no}.
    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    // x + y: no zeroing, no negation, adder selected, output not inverted.
    localparam logic [5:0] ALU_ADD = 6'b000010;

endpackage

// File: rtl/mul16_seq_alu.sv
// Combinational ALU: optional zero/invert on each operand, add or AND,
// optional output invert, plus zero and negative flags.
// Ports: i_x/i_y operands, i_zx/i_nx/i_zy/i_ny/i_f/i_no controls,
//        o_out result, o_zr (o_out == 0), o_ng (o_out MSB).
module mul16_seq_alu
    import mul16_seq_pkg::*;
(
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_zx,
    input  logic             i_nx,
    input  logic             i_zy,
    input  logic             i_ny,
    input  logic             i_f,
    input  logic             i_no,
    output logic [WIDTH-1:0] o_out,
    output logic             o_zr,
    output logic             o_ng
);

    logic [WIDTH-1:0] w_x0;
    logic [WIDTH-1:0] w_x1;
    logic [WIDTH-1:0] w_y0;
    logic [WIDTH-1:0] w_y1;
    logic [WIDTH-1:0] w_f;

    assign w_x0  = i_zx ? '0 : i_x;
    assign w_x1  = i_nx ? ~w_x0 : w_x0;
    assign w_y0  = i_zy ? '0 : i_y;
    assign w_y1  = i_ny ? ~w_y0 : w_y0;
    // Carry-out of the sum is dropped: results wrap modulo 2^WIDTH.
    assign w_f   = i_f ? (w_x1 + w_y1) : (w_x1 & w_y1);
    assign o_out = i_no ? ~w_f : w_f;
    assign o_zr  = (o_out == '0);
    assign o_ng  = o_out[WIDTH-1];

endmodule

// File: rtl/mul16_seq.sv
// Sequential 16x16 -> 16 (low half) shift-and-add multiplier sharing one ALU.
// Ports: clock, reset (async, active-high); start/a/b request; busy while
//        working, done one-cycle pulse, product (held), zero (product == 0).
module mul16_seq
    import mul16_seq_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             zero
);

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_product;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_alu_x;
    logic [WIDTH-1:0] w_alu_y;
    logic [WIDTH-1:0] w_alu_out;
    logic             w_alu_zr;
    logic             w_alu_ng;
    alu_ctrl_t        w_alu_ctrl;

    logic             w_accept;
    logic             w_last;
    logic             w_unused_alu_flags;

    // A new request is only taken when no operation is in flight.
    assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last     = (r_cnt == LAST_CNT);
    assign w_alu_ctrl = ALU_ADD;

    // The zero output is derived from the held product, so the ALU flags
    // are not needed.
    assign w_unused_alu_flags = ^{w_alu_zr, w_alu_ng};

    mul16_seq_alu u_alu (
        .i_x   (w_alu_x),
        .i_y   (w_alu_y),
        .i_zx  (w_alu_ctrl.zx),
        .i_nx  (w_alu_ctrl.nx),
        .i_zy  (w_alu_ctrl.zy),
        .i_ny  (w_alu_ctrl.ny),
        .i_f   (w_alu_ctrl.f),
        .i_no  (w_alu_ctrl.no),
        .o_out (w_alu_out),
        .o_zr  (w_alu_zr),
        .o_ng  (w_alu_ng)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = w_accept ? ADD : IDLE;
            ADD:     w_next_state = DBL;
            DBL:     w_next_state = w_last ? DONE : ADD;
            DONE:    w_next_state = w_accept ? ADD : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs and ALU operand mux.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        w_alu_x = r_acc;
        w_alu_y = r_mcand;
        case (r_state)
            ADD: begin
                busy    = 1'b1;
                w_alu_x = r_acc;
                w_alu_y = r_mcand;
            end
            DBL: begin
                // mcand + mcand is the left shift by one.
                busy    = 1'b1;
                w_alu_x = r_mcand;
                w_alu_y = r_mcand;
            end
            DONE: begin
                done    = 1'b1;
            end
            default: begin
                busy    = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_acc    <= '0;
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_cnt    <= '0;
                    end
                end
                ADD: begin
                    if (r_mplier[0]) begin
                        r_acc <= w_alu_out;
                    end
                end
                DBL: begin
                    r_mcand  <= w_alu_out;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    // acc is final after the last ADD; publish it as DONE is entered.
                    if (w_last) begin
                        r_product <= r_acc;
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign product = r_product;
    assign zero    = (r_product == '0);

endmodule

// File: tb/tb_mul16_seq.sv
module tb_mul16_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        zero;

    int n_checks;
    int n_fail;

    mul16_seq dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .zero    (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue a one-cycle start; returns at the falling edge after the start edge.
    task automatic start_op(input logic [15:0] va, input logic [15:0] vb);
        @(negedge clock);
        start = 1'b1;
        a     = va;
        b     = vb;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Wait (bounded) for done, counting falling edges with busy high.
    task automatic wait_done(output int nbusy, output bit got);
        nbusy = 0;
        got   = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (busy === 1'b1) nbusy++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (product !== 16'h0000) begin n_fail++; $display("FAIL reset_product got %h want 0000", product); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %b want 1", zero); end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int nb; bit got;
        start_op(16'd3, 16'd5);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_first got %b want 1", busy); end
        wait_done(nb, got);
        n_checks++; if (!got) begin n_fail++; $display("FAIL basic_timeout no done within bound"); end
        n_checks++; if (nb !== 32) begin n_fail++; $display("FAIL basic_latency got %0d busy cycles want 32", nb); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
        n_checks++; if (product !== 16'h000F) begin n_fail++; $display("FAIL basic_product got %h want 000f", product); end
        n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL basic_zero got %b want 0", zero); end
        @(negedge clock);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done); end
        n_checks++; if (product !== 16'h000F) begin n_fail++; $display("FAIL basic_hold got %h want 000f", product); end
    endtask

    task automatic test_vectors();
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic [15:0] ve [5];
        int nb; bit got;
        va[0] = 16'hFFFF; vb[0] = 16'hFFFF; ve[0] = 16'h0001;
        va[1] = 16'd300;  vb[1] = 16'd300;  ve[1] = 16'h5F90;
        va[2] = 16'hFFF9; vb[2] = 16'd6;    ve[2] = 16'hFFD6;
        va[3] = 16'd1234; vb[3] = 16'd0;    ve[3] = 16'h0000;
        va[4] = 16'h8000; vb[4] = 16'd2;    ve[4] = 16'h0000;
        for (int k = 0; k < 5; k++) begin
            start_op(va[k], vb[k]);
            wait_done(nb, got);
            n_checks++; if (!got || nb !== 32) begin n_fail++; $display("FAIL vec%0d_latency got %0d done=%b want 32", k, nb, got); end
            n_checks++; if (product !== ve[k]) begin n_fail++; $display("FAIL vec%0d_product got %h want %h", k, product, ve[k]); end
            n_checks++; if (zero !== (ve[k] == 16'h0000)) begin n_fail++; $display("FAIL vec%0d_zero got %b want %b", k, zero, (ve[k] == 16'h0000)); end
        end
    endtask

    task automatic test_ignore_start();
        int nb; bit got;
        start_op(16'd2, 16'd2);
        repeat (9) @(negedge clock);
        start = 1'b1; a = 16'd9; b = 16'd9;
        @(negedge clock);
        start = 1'b0;
        wait_done(nb, got);
        n_checks++; if (!got || nb !== 22) begin n_fail++; $display("FAIL ignore_latency got %0d done=%b want 22", nb, got); end
        n_checks++; if (product !== 16'h0004) begin n_fail++; $display("FAIL ignore_product got %h want 0004", product); end
    endtask

    task automatic test_back_to_back();
        int nb; bit got;
        @(negedge clock);
        start = 1'b1; a = 16'd3; b = 16'd7;
        @(negedge clock);
        wait_done(nb, got);
        n_checks++; if (!got || nb !== 32) begin n_fail++; $display("FAIL b2b_first_latency got %0d done=%b want 32", nb, got); end
        n_checks++; if (product !== 16'd21) begin n_fail++; $display("FAIL b2b_first_product got %h want 0015", product); end
        a = 16'd5; b = 16'd5;
        @(negedge clock);
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_no_idle got busy=%b done=%b want busy=1 done=0", busy, done); end
        start = 1'b0;
        wait_done(nb, got);
        n_checks++; if (!got || nb !== 32) begin n_fail++; $display("FAIL b2b_second_latency got %0d done=%b want 32", nb, got); end
        n_checks++; if (product !== 16'd25) begin n_fail++; $display("FAIL b2b_second_product got %h want 0019", product); end
    endtask

    task automatic test_reset_mid();
        int nb; bit got; int ndone;
        start_op(16'd100, 16'd3);
        repeat (14) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_checks++; if (product !== 16'h0000) begin n_fail++; $display("FAIL midrst_product got %h want 0000", product); end
        n_checks++; if (zero !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_flags got zero=%b done=%b want zero=1 done=0", zero, done); end
        @(negedge clock);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done === 1'b1) ndone++;
        end
        n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL midrst_no_done got %0d pulses want 0", ndone); end
        start_op(16'd100, 16'd3);
        wait_done(nb, got);
        n_checks++; if (!got || nb !== 32) begin n_fail++; $display("FAIL midrst_restart_latency got %0d done=%b want 32", nb, got); end
        n_checks++; if (product !== 16'h012C) begin n_fail++; $display("FAIL midrst_restart_product got %h want 012c", product); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        a        = 16'h0000;
        b        = 16'h0000;
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
